kvs_req_arbiter: RTL and testbench

KVS_REQ_ARBITER -- requirements
Module: kvs_req_arbiter

---
 rtl/kvs_req_arbiter.sv | 143 ++++++++++++++
 tb/tb_kvs_req_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kvs_req_arbiter.sv
// kvs_req_arbiter: packet-granular round-robin merge of the host and loopback request
// streams into the KVS, tracking in-flight requests from the response tap.
//
// state | meaning
// IDLE  | bubble cycle between packets; arbitration happens here, no stream connected
// PASS  | granted stream routed to m_* until its tlast beat is accepted
module kvs_req_arbiter #(
  parameter int DATA_W    = 256,
  parameter int KEEP_W    = 32,
  parameter int USER_W    = 64,
  parameter int MAX_OUTST = 8
) (
  input  logic              RX_clk,
  input  logic              RX_rst_n,

  input  logic [DATA_W-1:0] s0_tdata,
  input  logic [KEEP_W-1:0] s0_tkeep,
  input  logic [USER_W-1:0] s0_tuser,
  input  logic              s0_tvalid,
  input  logic              s0_tlast,
  output logic              s0_tready,

  input  logic [DATA_W-1:0] s1_tdata,
  input  logic [KEEP_W-1:0] s1_tkeep,
  input  logic [USER_W-1:0] s1_tuser,
  input  logic              s1_tvalid,
  input  logic              s1_tlast,
  output logic              s1_tready,

  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,

  input  logic              rsp_tvalid,
  input  logic              rsp_tready,
  input  logic              rsp_tlast,

  output logic [7:0]        outstanding,
  output logic              grant,
  output logic              busy,
  output logic              underflow_err
);

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  localparam logic [7:0] MAX_OUTST_C = 8'(MAX_OUTST);

  state_t state;
  logic   rst_sync_n;
  logic   last_grant;
  logic   req_any;
  logic   can_grant;
  logic   sel_s1;
  logic   sel_tvalid;
  logic   pkt_done;
  logic   rsp_done;

  // Reset asserts asynchronously; release is seen one edge later so the first
  // grant can land on the second edge after RX_rst_n rises.
  always_ff @(posedge RX_clk or negedge RX_rst_n) begin
    if (!RX_rst_n) begin
      rst_sync_n <= 1'b0;
    end else begin
      rst_sync_n <= 1'b1;
    end
  end

  assign req_any   = s0_tvalid | s1_tvalid;
  assign can_grant = req_any & (outstanding < MAX_OUTST_C);
  assign sel_s1    = (s0_tvalid & s1_tvalid) ? ~last_grant : s1_tvalid;

  assign sel_tvalid = grant ? s1_tvalid : s0_tvalid;
  assign m_tvalid   = busy & sel_tvalid;
  assign m_tdata    = grant ? s1_tdata : s0_tdata;
  assign m_tkeep    = grant ? s1_tkeep : s0_tkeep;
  assign m_tuser    = grant ? s1_tuser : s0_tuser;
  assign m_tlast    = grant ? s1_tlast : s0_tlast;

  assign s0_tready = busy & ~grant & m_tready;
  assign s1_tready = busy &  grant & m_tready;

  assign pkt_done = m_tvalid & m_tready & m_tlast;
  assign rsp_done = rsp_tvalid & rsp_tready & rsp_tlast;

  always_ff @(posedge RX_clk or negedge RX_rst_n) begin
    if (!RX_rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else if (rst_sync_n) begin
      case (state)
        IDLE: begin
          if (can_grant) begin
            state <= PASS;
            busy  <= 1'b1;
            grant <= sel_s1;
          end
        end
        PASS: begin
          if (pkt_done) begin
            state      <= IDLE;
            busy       <= 1'b0;
            last_grant <= grant;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A completed packet and a completed response in the same cycle cancel out.
  always_ff @(posedge RX_clk or negedge RX_rst_n) begin
    if (!RX_rst_n) begin
      outstanding   <= 8'd0;
      underflow_err <= 1'b0;
    end else if (rst_sync_n) begin
      case ({pkt_done, rsp_done})
        2'b10: outstanding <= outstanding + 8'd1;
        2'b01: begin
          if (outstanding == 8'd0) begin
            underflow_err <= 1'b1;
          end else begin
            outstanding <= outstanding - 8'd1;
          end
        end
        default: begin
          outstanding <= outstanding;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kvs_req_arbiter.sv
// tb_kvs_req_arbiter: random two-source traffic against a packet-level reference model,
// with per-stream expected-beat queues popped by a negedge monitor.
module tb_kvs_req_arbiter;

  localparam int DATA_W = 256;
  localparam int KEEP_W = 32;
  localparam int USER_W = 64;
  localparam int MAX    = 2;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;
    logic [USER_W-1:0] u;
    logic              l;
  } beat_t;

  logic              RX_clk = 1'b0;
  logic              RX_rst_n = 1'b1;
  logic [DATA_W-1:0] s0_tdata = '0, s1_tdata = '0;
  logic [KEEP_W-1:0] s0_tkeep = '0, s1_tkeep = '0;
  logic [USER_W-1:0] s0_tuser = '0, s1_tuser = '0;
  logic              s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic              s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic              s0_tready, s1_tready;
  logic [DATA_W-1:0] m_tdata;
  logic [KEEP_W-1:0] m_tkeep;
  logic [USER_W-1:0] m_tuser;
  logic              m_tvalid, m_tlast;
  logic              m_tready = 1'b0;
  logic              rsp_tvalid = 1'b0, rsp_tready = 1'b0, rsp_tlast = 1'b0;
  logic [7:0]        outstanding;
  logic              grant, busy, underflow_err;

  kvs_req_arbiter #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W), .MAX_OUTST(MAX)
  ) dut (
    .RX_clk(RX_clk), .RX_rst_n(RX_rst_n),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tuser(s0_tuser),
    .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tuser(s1_tuser),
    .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tlast(rsp_tlast),
    .outstanding(outstanding), .grant(grant), .busy(busy),
    .underflow_err(underflow_err)
  );

  always #5 RX_clk = ~RX_clk;

  int n_chk = 0;
  int n_pass = 0;

  beat_t srcq0[$], srcq1[$];
  beat_t expq0[$], expq1[$];
  logic  hs0 = 1'b0, hs1 = 1'b0;
  logic  gen_en = 1'b0;
  logic  run = 1'b0;

  // Reference model: packet-level view of the arbiter.
  logic  m_pass = 1'b0;
  logic  m_grant = 1'b0;
  logic  m_last = 1'b1;
  logic  m_uflow = 1'b0;
  logic  m_sync = 1'b0;
  int    m_outst = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic gen_pkt(input int i);
    beat_t b;
    int    n;
    n = int'($urandom_range(1, 4));
    for (int j = 0; j < n; j++) begin
      b.d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b.k = $urandom;
      b.u = {$urandom, $urandom};
      b.l = (j == n - 1);
      if (i == 0) begin
        srcq0.push_back(b);
        expq0.push_back(b);
      end else begin
        srcq1.push_back(b);
        expq1.push_back(b);
      end
    end
  endtask

  task automatic apply_beats();
    if (srcq0.size() != 0) begin
      s0_tdata = srcq0[0].d; s0_tkeep = srcq0[0].k; s0_tuser = srcq0[0].u; s0_tlast = srcq0[0].l;
    end
    if (srcq1.size() != 0) begin
      s1_tdata = srcq1[0].d; s1_tkeep = srcq1[0].k; s1_tuser = srcq1[0].u; s1_tlast = srcq1[0].l;
    end
  endtask

  // Called at posedge+1: retire accepted beats, then present the next stimulus.
  task automatic drive_cycle();
    if (hs0) void'(srcq0.pop_front());
    if (hs1) void'(srcq1.pop_front());
    if (gen_en && srcq0.size() == 0 && $urandom_range(0, 3) == 0) gen_pkt(0);
    if (gen_en && srcq1.size() == 0 && $urandom_range(0, 3) == 0) gen_pkt(1);
    if (srcq0.size() == 0) s0_tvalid = 1'b0;
    else if (!s0_tvalid || hs0) s0_tvalid = ($urandom_range(0, 4) != 0);
    if (srcq1.size() == 0) s1_tvalid = 1'b0;
    else if (!s1_tvalid || hs1) s1_tvalid = ($urandom_range(0, 4) != 0);
    apply_beats();
    m_tready   = ($urandom_range(0, 3) != 0);
    rsp_tvalid = ($urandom_range(0, 1) == 1);
    rsp_tready = ($urandom_range(0, 3) != 0);
    rsp_tlast  = ($urandom_range(0, 2) == 0);
  endtask

  // Monitor: inputs are stable at negedge and equal what the DUT samples at the next posedge.
  always @(negedge RX_clk) begin : mon
    logic  inc, dec, sv, qok;
    beat_t e;
    if (run) begin
      if (!RX_rst_n) begin
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s0_tready", s0_tready, 0);
        chk("rst_s1_tready", s1_tready, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underflow", underflow_err, 0);
        m_pass = 1'b0; m_grant = 1'b0; m_last = 1'b1;
        m_uflow = 1'b0; m_outst = 0; m_sync = 1'b0;
        hs0 = 1'b0; hs1 = 1'b0;
      end else begin
        hs0 = s0_tvalid & s0_tready;
        hs1 = s1_tvalid & s1_tready;
        inc = 1'b0;
        dec = rsp_tvalid & rsp_tready & rsp_tlast;
        chk("outstanding", outstanding, m_outst);
        chk("underflow_err", underflow_err, m_uflow);
        chk("grant", grant, m_grant);
        chk("busy", busy, m_pass);
        if (!m_pass) begin
          chk("idle_m_tvalid", m_tvalid, 0);
          chk("idle_s0_tready", s0_tready, 0);
          chk("idle_s1_tready", s1_tready, 0);
          if (m_sync && (s0_tvalid || s1_tvalid) && m_outst < MAX) begin
            // lone requester wins; with two, the one not served last time
            m_grant = (s0_tvalid && s1_tvalid) ? ~m_last : s1_tvalid;
            m_pass  = 1'b1;
          end
        end else begin
          sv = m_grant ? s1_tvalid : s0_tvalid;
          chk("m_tvalid", m_tvalid, sv);
          chk("granted_tready", m_grant ? s1_tready : s0_tready, m_tready);
          chk("other_tready", m_grant ? s0_tready : s1_tready, 0);
          if (sv && m_tready) begin
            qok = m_grant ? (expq1.size() != 0) : (expq0.size() != 0);
            chk("exp_queue_nonempty", qok, 1);
            if (qok) begin
              e = m_grant ? expq1.pop_front() : expq0.pop_front();
              chk("m_tdata", m_tdata, e.d);
              chk("m_tkeep", m_tkeep, e.k);
              chk("m_tuser", m_tuser, e.u);
              chk("m_tlast", m_tlast, e.l);
              if (e.l) begin
                m_pass = 1'b0;
                m_last = m_grant;
                inc    = 1'b1;
              end
            end
          end
        end
        if (m_sync) begin
          if (inc && !dec) m_outst++;
          else if (dec && !inc) begin
            if (m_outst == 0) m_uflow = 1'b1;
            else m_outst--;
          end
        end
        m_sync = 1'b1;
      end
    end
  end

  initial begin
    logic found, got;
    run = 1'b1;
    #2 RX_rst_n = 1'b0;
    repeat (3) @(posedge RX_clk);
    #1 RX_rst_n = 1'b1;

    // Response completing with nothing in flight.
    repeat (3) begin @(posedge RX_clk); #1; end
    rsp_tvalid = 1'b1; rsp_tready = 1'b1; rsp_tlast = 1'b1;
    @(posedge RX_clk); #1;
    rsp_tvalid = 1'b0; rsp_tready = 1'b0; rsp_tlast = 1'b0;
    @(negedge RX_clk);
    chk("underflow_set", underflow_err, 1);
    chk("underflow_count_zero", outstanding, 0);

    gen_en = 1'b1;
    repeat (1500) begin @(posedge RX_clk); #1; drive_cycle(); end

    // Abort a packet mid-flight with reset.
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(posedge RX_clk); #1;
      drive_cycle();
      if (m_pass && (m_grant ? s1_tvalid : s0_tvalid)) found = 1'b1;
    end
    chk("midpkt_found", found, 1);
    #2 RX_rst_n = 1'b0;
    #1;
    chk("abort_m_tvalid", m_tvalid, 0);
    chk("abort_s0_tready", s0_tready, 0);
    chk("abort_s1_tready", s1_tready, 0);
    chk("abort_outstanding", outstanding, 0);
    srcq0.delete(); srcq1.delete(); expq0.delete(); expq1.delete();
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    rsp_tvalid = 1'b0; rsp_tready = 1'b0; rsp_tlast = 1'b0;
    repeat (3) @(posedge RX_clk);
    #1 RX_rst_n = 1'b1;
    gen_pkt(0); gen_pkt(1);
    s0_tvalid = 1'b1; s1_tvalid = 1'b1; m_tready = 1'b1;
    apply_beats();
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge RX_clk); #1;
      if (busy) begin
        chk("post_reset_grant_s0", grant, 0);
        got = 1'b1;
      end
      drive_cycle();
    end
    chk("post_reset_grant_seen", got, 1);

    repeat (1500) begin @(posedge RX_clk); #1; drive_cycle(); end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
